// File: rtl/irq_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the machine-mode interrupt controller.
package irq_ctrl_pkg;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    // Bit positions shared by mie and mip, plus mstatus.MIE
    localparam int MSI_BIT     = 3;
    localparam int MTI_BIT     = 7;
    localparam int MEI_BIT     = 11;
    localparam int MSTATUS_MIE = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } irq_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Request/ack handshake between the interrupt controller and the exception sequencer.
interface irq_ctrl_if #(
    parameter int NUM_EXT = 4
);
    import irq_ctrl_pkg::*;

    localparam int ID_W = id_width(NUM_EXT);

    logic            irq_req_o;
    logic [31:0]     irq_cause_o;
    logic            irq_ack_i;
    logic [ID_W-1:0] ext_id_o;

    modport master (
        output irq_req_o,
        output irq_cause_o,
        output ext_id_o,
        input  irq_ack_i
    );

    modport slave (
        input  irq_req_o,
        input  irq_cause_o,
        input  ext_id_o,
        output irq_ack_i
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any line is pending and the lowest pending index.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_EXT = 4,
    parameter int ID_W    = id_width(NUM_EXT)
) (
    input  logic [NUM_EXT-1:0] pend,
    output logic               any,
    output logic [ID_W-1:0]    id
);

    // Scan downwards so the lowest set index is the last one written
    always_comb begin
        any = |pend;
        id  = '0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (pend[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches external edges, masks and prioritises sources, and
// holds one request for the exception sequencer until mret re-opens it.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_EXT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               timer_irq_i,
    input  logic               soft_irq_i,
    input  logic [NUM_EXT-1:0] ext_irq_i,
    input  logic [31:0]        csr_mstatus_i,
    input  logic [31:0]        csr_mie_i,
    input  logic               excp_busy_i,
    input  logic               mret_i,
    irq_ctrl_if.master         irq_bus,
    output logic [31:0]        mip_o
);

    localparam int ID_W = id_width(NUM_EXT);

    irq_state_e         state_q, state_d;
    logic [NUM_EXT-1:0] ext_prev, ext_pend, pend_clr;
    logic [31:0]        cause_q, cause_d;
    logic [ID_W-1:0]    id_q, id_d, enc_id;
    logic               req_q, enc_any;
    logic               mei_elig, msi_elig, mti_elig, cur_elig;
    logic [31:0]        mip_d;
    logic               unused_csr_bits;

    assign unused_csr_bits = ^{csr_mstatus_i, csr_mie_i};

    irq_prio_enc #(
        .NUM_EXT (NUM_EXT),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .pend (ext_pend),
        .any  (enc_any),
        .id   (enc_id)
    );

    assign mei_elig = enc_any     & csr_mie_i[MEI_BIT] & csr_mstatus_i[MSTATUS_MIE];
    assign msi_elig = soft_irq_i  & csr_mie_i[MSI_BIT] & csr_mstatus_i[MSTATUS_MIE];
    assign mti_elig = timer_irq_i & csr_mie_i[MTI_BIT] & csr_mstatus_i[MSTATUS_MIE];

    always_comb begin
        cur_elig = 1'b0;
        if (cause_q == CAUSE_MEI) begin
            cur_elig = (|(ext_pend & (NUM_EXT'(1) << id_q))) & csr_mie_i[MEI_BIT]
                       & csr_mstatus_i[MSTATUS_MIE];
        end else if (cause_q == CAUSE_MSI) begin
            cur_elig = msi_elig;
        end else if (cause_q == CAUSE_MTI) begin
            cur_elig = mti_elig;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        id_d     = id_q;
        pend_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if ((mei_elig || msi_elig || mti_elig) && !excp_busy_i) begin
                    state_d = ST_REQ;
                    if (mei_elig) begin
                        cause_d = CAUSE_MEI;
                        id_d    = enc_id;
                    end else if (msi_elig) begin
                        cause_d = CAUSE_MSI;
                        id_d    = '0;
                    end else begin
                        cause_d = CAUSE_MTI;
                        id_d    = '0;
                    end
                end
            end
            ST_REQ: begin
                // Ack takes priority over a simultaneous loss of eligibility
                if (irq_bus.irq_ack_i) begin
                    state_d = ST_ACTIVE;
                    if (cause_q == CAUSE_MEI) begin
                        pend_clr = NUM_EXT'(1) << id_q;
                    end
                end else if (!cur_elig) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (mret_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mip_d          = '0;
        mip_d[MEI_BIT] = |ext_pend;
        mip_d[MTI_BIT] = timer_irq_i;
        mip_d[MSI_BIT] = soft_irq_i;
    end

    // A fresh edge in the same cycle as an ack clear re-pends the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ext_prev <= '0;
            ext_pend <= '0;
            cause_q  <= '0;
            id_q     <= '0;
            req_q    <= 1'b0;
            mip_o    <= '0;
        end else begin
            state_q  <= state_d;
            ext_prev <= ext_irq_i;
            ext_pend <= (ext_pend & ~pend_clr) | (ext_irq_i & ~ext_prev);
            cause_q  <= cause_d;
            id_q     <= id_d;
            req_q    <= (state_d == ST_REQ);
            mip_o    <= mip_d;
        end
    end

    assign irq_bus.irq_req_o   = req_q;
    assign irq_bus.irq_cause_o = cause_q;
    assign irq_bus.ext_id_o    = id_q;

endmodule
